attempt_counter: RTL and testbench

- Tracks failed password attempts for the password lock and drives the 3-bit attempt count into the counter seven-segment decoder, which displays values 0-5.
- Sits between the password comparator, which reports each check result, and the counter display decoder.
- Enforces a timed lockout after MAX_ATTEMPTS consecutive failures.
- Reports the unlocked/open condition to the door-control logic.

---
 rtl/attempt_counter.sv | 124 ++++++++++++
 tb/tb_attempt_counter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/attempt_counter.sv
// Failed-attempt counter with timed lockout (optional escalation via LOCKOUT_ESCALATE_EN).
// Latency: 1 cycle, all outputs registered; no backpressure, inputs are sampled every cycle.
module attempt_counter #(
  parameter int MAX_ATTEMPTS   = 5,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int TIMER_W        = 29
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_valid,
  input  logic       check_match,
  input  logic       relock,
  output logic [2:0] count,
  output logic       unlocked,
  output logic       locked_out,
  output logic       lockout_done
);

  localparam logic [2:0]         MAX_CNT = 3'(MAX_ATTEMPTS);
  localparam logic [63:0]        BASE    = 64'(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);
`ifdef LOCKOUT_ESCALATE_EN
  localparam logic [63:0]        MAX_LOAD = (BASE << 3) - 64'd1;
`else
  localparam logic [63:0]        MAX_LOAD = BASE - 64'd1;
`endif

  generate
    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 5) begin : g_bad_max_attempts
      $error("attempt_counter: MAX_ATTEMPTS must be in 1..5");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout_cycles
      $error("attempt_counter: LOCKOUT_CYCLES must be at least 1");
    end
    if (TIMER_W < 64 && MAX_LOAD >= (64'd1 << TIMER_W)) begin : g_bad_timer_w
      $error("attempt_counter: TIMER_W too narrow for the longest lockout");
    end
  endgenerate

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] load_val;
  logic [2:0]         count_inc;

  assign count_inc = count + 3'd1;

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] level;

  // Each level doubles the previous lockout: 1x, 2x, 4x, 8x.
  assign load_val = TIMER_W'((BASE << level) - 64'd1);
`else
  assign load_val = TIMER_W'(BASE - 64'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARMED;
      count        <= 3'd0;
      unlocked     <= 1'b0;
      locked_out   <= 1'b0;
      lockout_done <= 1'b0;
      timer        <= '0;
`ifdef LOCKOUT_ESCALATE_EN
      level        <= 2'd0;
`endif
    end else begin
      lockout_done <= 1'b0;
      case (state)
        ARMED: begin
          if (check_valid) begin
            if (check_match) begin
              state    <= OPEN;
              count    <= 3'd0;
              unlocked <= 1'b1;
`ifdef LOCKOUT_ESCALATE_EN
              level    <= 2'd0;
`endif
            end else if (count_inc == MAX_CNT) begin
              // count stays at MAX_ATTEMPTS for the whole lockout so the display shows it
              state      <= LOCKOUT;
              count      <= count_inc;
              locked_out <= 1'b1;
              timer      <= load_val;
            end else begin
              count <= count_inc;
            end
          end
        end
        OPEN: begin
          if (relock) begin
            state    <= ARMED;
            unlocked <= 1'b0;
            count    <= 3'd0;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state        <= ARMED;
            count        <= 3'd0;
            locked_out   <= 1'b0;
            lockout_done <= 1'b1;
`ifdef LOCKOUT_ESCALATE_EN
            if (level != 2'd3) level <= level + 2'd1;
`endif
          end else begin
            timer <= timer - T_ONE;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= MAX_CNT);
  open_excl: assert property (@(posedge clk) disable iff (!rst_n) !(unlocked && locked_out));

endmodule

// File: tb/tb_attempt_counter.sv
// Scoreboarded bench for attempt_counter: directed scenarios then random checks.
// Expected outputs come from a cycle-level behavioural model; a monitor compares every cycle.
module tb_attempt_counter;
  localparam int MAXA = 5;
  localparam int LC   = 10;
  localparam int TW   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       check_valid = 1'b0;
  logic       check_match = 1'b0;
  logic       relock = 1'b0;
  logic [2:0] count;
  logic       unlocked;
  logic       locked_out;
  logic       lockout_done;

  always #5 clk = ~clk;

  attempt_counter #(
    .MAX_ATTEMPTS(MAXA),
    .LOCKOUT_CYCLES(LC),
    .TIMER_W(TW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .check_valid(check_valid),
    .check_match(check_match),
    .relock(relock),
    .count(count),
    .unlocked(unlocked),
    .locked_out(locked_out),
    .lockout_done(lockout_done)
  );

  typedef struct {
    int cnt;
    bit unl;
    bit lo;
    bit dn;
  } exp_t;

  exp_t q[$];
  int   dq[$];
  int   total = 0;
  int   bad = 0;

  // Behavioural model: failures so far, open flag, lockout cycles still to show.
  int m_fails = 0;
  int m_lock_left = 0;
  int m_level = 0;
  bit m_open = 0;
  bit m_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lock_duration();
`ifdef LOCKOUT_ESCALATE_EN
    return LC * (1 << m_level);
`else
    return LC;
`endif
  endfunction

  task automatic model_step(input bit cv, input bit cm, input bit rl);
    m_done = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_fails = 0;
        m_done  = 1;
        if (m_level < 3) m_level++;
      end
    end else if (m_open) begin
      if (rl) m_open = 0;
    end else if (cv) begin
      if (cm) begin
        m_open  = 1;
        m_fails = 0;
        m_level = 0;
      end else begin
        m_fails++;
        if (m_fails == MAXA) begin
          m_lock_left = lock_duration();
          dq.push_back(m_lock_left);
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cnt = m_fails;
    e.unl = m_open;
    e.lo  = (m_lock_left > 0);
    e.dn  = m_done;
    q.push_back(e);
  endtask

  task automatic cycle(input bit cv, input bit cm, input bit rl);
    @(negedge clk);
    check_valid = cv;
    check_match = cm;
    relock      = rl;
    model_step(cv, cm, rl);
    push_exp();
  endtask

  task automatic fail_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_lockout();
    while (m_lock_left > 0) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Reset is asserted between clock edges and its effect checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    check_valid = 1'b0;
    check_match = 1'b0;
    relock      = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_unlocked", int'(unlocked), 0);
    chk("rst_locked_out", int'(locked_out), 0);
    chk("rst_lockout_done", int'(lockout_done), 0);
    m_fails = 0; m_lock_left = 0; m_level = 0; m_open = 0; m_done = 0;
    dq.delete();
    push_exp();
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0);
    push_exp();
  endtask

  // Monitor: compares every cycle, and measures each locked_out run length.
  int run = 0;
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count", int'(count), e.cnt);
      chk("unlocked", int'(unlocked), int'(e.unl));
      chk("locked_out", int'(locked_out), int'(e.lo));
      chk("lockout_done", int'(lockout_done), int'(e.dn));
    end
    if (!rst_n) begin
      run = 0;
    end else if (locked_out) begin
      run++;
    end else if (run > 0) begin
      chk("lockout_len", run, (dq.size() > 0) ? dq.pop_front() : -1);
      run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    do_reset();

    // Count steps, match opens, relock closes.
    fail_n(3);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Full lockout, with ignored check/relock traffic inside it.
    fail_n(MAXA);
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    wait_lockout();

    // Relock beats a simultaneous check in OPEN.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset with the lockout timer at 4, then one failure.
    fail_n(MAXA);
    while (m_lock_left != 5) cycle(1'b0, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-to-back lockouts, then a match and one more lockout.
    repeat (3) begin
      fail_n(MAXA);
      wait_lockout();
    end
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    fail_n(MAXA);
    wait_lockout();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0);
    end

    wait_lockout();
    cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    chk("lockouts_all_seen", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
